// File: rtl/config_pkg.sv
// config_pkg: shared widths, sync word and packer state encoding for the config path
package config_pkg;
  localparam int CONFIG_WORD_WIDTH = 32;
  localparam int CONFIG_BYTE_WIDTH = 8;
  localparam logic [31:0] CONFIG_SYNC_WORD = 32'hFAB0_FAB1;
  typedef enum logic {IDLE, ACTIVE} packer_state_e;
endpackage

// File: rtl/config_activity_timer.sv
// config_activity_timer: idle-cycle counter with reload, saturation at the limit and an expire flag
module config_activity_timer #(
  parameter int TimeoutCycles = 10000,
  parameter int TimeoutWidth = 16
) (
  input  logic CLK,
  input  logic Reset,
  input  logic Active,
  input  logic Reload,
  input  logic Clear,
  output logic Expire
);
  localparam logic [TimeoutWidth-1:0] Limit = TimeoutWidth'(TimeoutCycles);
  logic [TimeoutWidth-1:0] count;
  assign Expire = Active && count == Limit;
  always_ff @(posedge CLK) begin
    if (Reset || Reload || Clear || !Active) count <= '0;
    else if (count != Limit) count <= count + TimeoutWidth'(1);
  end
endmodule

// File: rtl/config_word_packer.sv
// config_word_packer: packs a byte stream into big-endian 32-bit config words with an idle timeout.
// CONFIG_PACKER_CHECKSUM_EN enables the per-session running byte sum on Checksum.
module config_word_packer
  import config_pkg::*;
#(
  parameter int TimeoutCycles = 10000,
  parameter int TimeoutWidth = 16
) (
  input  logic                         CLK,
  input  logic                         Reset,
  input  logic [CONFIG_BYTE_WIDTH-1:0] RxData,
  input  logic                         RxValid,
  output logic [CONFIG_WORD_WIDTH-1:0] WriteData,
  output logic                         WriteStrobe,
  output logic                         ComActive,
  output logic                         WordDropped,
  output logic [CONFIG_BYTE_WIDTH-1:0] Checksum
);
  localparam int PartialWidth = CONFIG_WORD_WIDTH - CONFIG_BYTE_WIDTH;
  packer_state_e state, state_next;
  logic [1:0] byte_idx;
  logic [PartialWidth-1:0] partial;
  logic expire, timeout;
  config_activity_timer #(.TimeoutCycles(TimeoutCycles), .TimeoutWidth(TimeoutWidth)) u_timer (
    .CLK(CLK),
    .Reset(Reset),
    .Active(state == ACTIVE),
    .Reload(RxValid),
    .Clear(timeout),
    .Expire(expire)
  );
  // a byte arriving on the expiry cycle keeps the session open
  assign timeout = expire && !RxValid;
  assign ComActive = state == ACTIVE;
  always_comb begin
    state_next = state;
    state_next = state == IDLE ? (RxValid ? ACTIVE : IDLE) : (timeout ? IDLE : ACTIVE);
  end
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= IDLE;
      byte_idx <= '0;
      partial <= '0;
      WriteData <= '0;
      WriteStrobe <= 1'b0;
      WordDropped <= 1'b0;
    end else begin
      state <= state_next;
      WriteStrobe <= RxValid && byte_idx == 2'd3;
      WordDropped <= timeout && byte_idx != 2'd0;
      if (RxValid) begin
        byte_idx <= byte_idx + 2'd1;
        partial <= byte_idx == 2'd3 ? '0 : {partial[PartialWidth-CONFIG_BYTE_WIDTH-1:0], RxData};
        if (byte_idx == 2'd3) WriteData <= {partial, RxData};
      end else if (timeout) begin
        byte_idx <= '0;
        partial <= '0;
      end
    end
  end
`ifdef CONFIG_PACKER_CHECKSUM_EN
  logic [CONFIG_BYTE_WIDTH-1:0] sum;
  always_ff @(posedge CLK) begin
    if (Reset) sum <= '0;
    else if (RxValid) sum <= (state == IDLE ? 8'h00 : sum) + RxData;
  end
  assign Checksum = sum;
`else
  assign Checksum = '0;
`endif
endmodule

// File: tb/tb_config_word_packer.sv
// tb_config_word_packer: scoreboard bench for config_word_packer with TimeoutCycles=8
module tb_config_word_packer;
  logic CLK = 1'b0;
  logic Reset = 1'b1;
  logic RxValid = 1'b0;
  logic [7:0] RxData = 8'h00;
  logic [31:0] WriteData;
  logic WriteStrobe, ComActive, WordDropped;
  logic [7:0] Checksum;
  int checks = 0;
  int errors = 0;
  int drops = 0;
  logic [31:0] exp_q[$];
  logic [31:0] pword = '0;
  logic [31:0] exp_w;
  int pidx = 0;

  config_word_packer #(.TimeoutCycles(8), .TimeoutWidth(4)) dut (
    .CLK(CLK),
    .Reset(Reset),
    .RxData(RxData),
    .RxValid(RxValid),
    .WriteData(WriteData),
    .WriteStrobe(WriteStrobe),
    .ComActive(ComActive),
    .WordDropped(WordDropped),
    .Checksum(Checksum)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (WordDropped) drops++;
    if (WriteStrobe) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected WriteData=%h required no strobe", WriteData);
      end else begin
        exp_w = exp_q.pop_front();
        if (WriteData !== exp_w) begin
          errors++;
          $display("FAIL scoreboard_word got %h required %h", WriteData, exp_w);
        end
      end
    end
`ifndef CONFIG_PACKER_CHECKSUM_EN
    checks++;
    if (Checksum !== 8'h00) begin
      errors++;
      $display("FAIL checksum_tied got %h required 00", Checksum);
    end
`endif
  end

  task automatic drive_byte(input logic [7:0] b);
    RxData = b;
    RxValid = 1'b1;
    pword = {pword[23:0], b};
    pidx++;
    if (pidx == 4) begin
      exp_q.push_back(pword);
      pidx = 0;
    end
    @(negedge CLK);
    RxValid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic expect_timeout(input string name, input logic drop);
    for (int k = 1; k <= 9; k++) begin
      @(negedge CLK);
      checks++;
      if (ComActive !== (k < 9)) begin
        errors++;
        $display("FAIL %s_active k=%0d got %b required %b", name, k, ComActive, k < 9);
      end
      checks++;
      if (WordDropped !== (drop && k == 9)) begin
        errors++;
        $display("FAIL %s_dropped k=%0d got %b required %b", name, k, WordDropped, drop && k == 9);
      end
    end
    pidx = 0;
  endtask

  task automatic test_reset();
    RxValid = 1'b1;
    RxData = 8'h55;
    idle(2);
    checks++;
    if ({WriteData, WriteStrobe, ComActive, WordDropped, Checksum} !== 43'h0) begin
      errors++;
      $display("FAIL reset_outputs got data=%h strb=%b act=%b drop=%b sum=%h required all zero",
               WriteData, WriteStrobe, ComActive, WordDropped, Checksum);
    end
    RxValid = 1'b0;
    Reset = 1'b0;
    idle(1);
    checks++;
    if (ComActive !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got %b required 0", ComActive);
    end
  endtask

  task automatic test_sync_word();
    drive_byte(8'hFA);
    checks++;
    if (ComActive !== 1'b1) begin
      errors++;
      $display("FAIL sync_active got %b required 1", ComActive);
    end
    drive_byte(8'hB0);
    drive_byte(8'hFA);
    drive_byte(8'hB1);
    checks++;
    if (WriteStrobe !== 1'b1 || WriteData !== 32'hFAB0FAB1) begin
      errors++;
      $display("FAIL sync_word got strb=%b data=%h required 1 FAB0FAB1", WriteStrobe, WriteData);
    end
    idle(1);
    checks++;
    if (WriteStrobe !== 1'b0 || WriteData !== 32'hFAB0FAB1) begin
      errors++;
      $display("FAIL sync_hold got strb=%b data=%h required 0 FAB0FAB1", WriteStrobe, WriteData);
    end
  endtask

  task automatic test_spaced();
    for (int i = 1; i <= 8; i++) begin
      drive_byte(8'(i));
      idle(2);
    end
    checks++;
    if (WriteData !== 32'h05060708 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL spaced_words got data=%h pending=%0d required 05060708 0", WriteData, exp_q.size());
    end
  endtask

  task automatic test_timeout();
    drive_byte(8'h11);
    drive_byte(8'h22);
    expect_timeout("timeout", 1'b1);
    idle(1);
    checks++;
    if (WordDropped !== 1'b0 || WriteData !== 32'h05060708) begin
      errors++;
      $display("FAIL timeout_after got drop=%b data=%h required 0 05060708", WordDropped, WriteData);
    end
    drive_byte(8'h31);
    drive_byte(8'h32);
    drive_byte(8'h33);
    drive_byte(8'h34);
    checks++;
    if (WriteStrobe !== 1'b1 || WriteData !== 32'h31323334) begin
      errors++;
      $display("FAIL timeout_restart got strb=%b data=%h required 1 31323334", WriteStrobe, WriteData);
    end
  endtask

  task automatic test_expiry_rxvalid();
    drive_byte(8'h41);
    idle(8);
    checks++;
    if (ComActive !== 1'b1) begin
      errors++;
      $display("FAIL expiry_pre got %b required 1", ComActive);
    end
    drive_byte(8'h42);
    checks++;
    if (ComActive !== 1'b1 || WordDropped !== 1'b0) begin
      errors++;
      $display("FAIL expiry_win got act=%b drop=%b required 1 0", ComActive, WordDropped);
    end
    expect_timeout("expiry_restart", 1'b1);
  endtask

  task automatic test_reset_mid();
    int d0;
    drive_byte(8'h61);
    drive_byte(8'h62);
    drive_byte(8'h63);
    d0 = drops;
    Reset = 1'b1;
    RxValid = 1'b1;
    RxData = 8'h77;
    idle(1);
    Reset = 1'b0;
    RxValid = 1'b0;
    pidx = 0;
    checks++;
    if (ComActive !== 1'b0 || WordDropped !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got act=%b drop=%b required 0 0", ComActive, WordDropped);
    end
    drive_byte(8'hAA);
    drive_byte(8'hBB);
    drive_byte(8'hCC);
    drive_byte(8'hDD);
    checks++;
    if (WriteStrobe !== 1'b1 || WriteData !== 32'hAABBCCDD) begin
      errors++;
      $display("FAIL reset_word got strb=%b data=%h required 1 AABBCCDD", WriteStrobe, WriteData);
    end
    idle(2);
    checks++;
    if (drops != d0) begin
      errors++;
      $display("FAIL reset_nodrop got %0d drops required %0d", drops, d0);
    end
  endtask

  task automatic test_checksum();
    logic [7:0] want;
    idle(12);
    checks++;
    if (ComActive !== 1'b0) begin
      errors++;
      $display("FAIL checksum_idle got %b required 0", ComActive);
    end
    drive_byte(8'hFF);
    drive_byte(8'h02);
    drive_byte(8'h10);
    drive_byte(8'h01);
`ifdef CONFIG_PACKER_CHECKSUM_EN
    want = 8'h12;
`else
    want = 8'h00;
`endif
    checks++;
    if (Checksum !== want) begin
      errors++;
      $display("FAIL checksum_sum got %h required %h", Checksum, want);
    end
    idle(12);
    drive_byte(8'h05);
`ifdef CONFIG_PACKER_CHECKSUM_EN
    want = 8'h05;
`else
    want = 8'h00;
`endif
    checks++;
    if (Checksum !== want) begin
      errors++;
      $display("FAIL checksum_restart got %h required %h", Checksum, want);
    end
    idle(12);
    pidx = 0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) drive_byte(8'($urandom_range(255)));
    idle(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL back_to_back_pending got %0d words required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_sync_word();
    test_spaced();
    test_timeout();
    test_expiry_rxvalid();
    test_reset_mid();
    test_checksum();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/config_word_packer.md
CONFIG_WORD_PACKER -- requirements
Module: config_word_packer

Interface
REQ-001 Parameter TimeoutCycles, default 10000: idle cycles without a byte before the session ends.
REQ-002 Parameter TimeoutWidth, default 16: timeout counter width; SHALL satisfy 2**TimeoutWidth > TimeoutCycles.
REQ-003 CLK  in  1  sole clock; all logic on rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 RxData  in  8  received byte from the serial receiver.
REQ-006 RxValid  in  1  one-cycle pulse; RxData valid in that cycle.
REQ-007 WriteData  out  32  assembled configuration word, registered.
REQ-008 WriteStrobe  out  1  one-cycle pulse; WriteData valid in that cycle.
REQ-009 ComActive  out  1  high while a session is open; rising edge restarts the downstream configuration FSM.
REQ-010 WordDropped  out  1  one-cycle pulse when a timeout discards a partial word.
REQ-011 Checksum  out  8  running byte sum of the session (see Configuration).

Function
REQ-012 States: IDLE (ComActive=0) and ACTIVE (ComActive=1).
REQ-013 IDLE + RxValid -> ACTIVE next cycle; that byte is captured as byte 0 of the first word.
REQ-014 Byte order big-endian: byte 0 -> WriteData[31:24], byte 1 -> [23:16], byte 2 -> [15:8], byte 3 -> [7:0].
REQ-015 2-bit byte index increments per RxValid, wraps 3 -> 0.
REQ-016 RxValid with index 3: WriteData updates and WriteStrobe is high in the next cycle (latency 1), for exactly one cycle.
REQ-017 WriteData holds its value until the next completed word; partial bytes go to a separate shift register.
REQ-018 Timeout counter reloads to 0 on every RxValid and increments each ACTIVE cycle without RxValid.
REQ-019 Counter reaching TimeoutCycles -> IDLE next cycle: ComActive=0, index=0, counter=0.
REQ-020 Timeout with index != 0: partial word discarded, WordDropped pulses one cycle together with ComActive falling; no WriteStrobe.
REQ-021 RxValid in the same cycle the counter reaches TimeoutCycles: RxValid wins, session stays ACTIVE, counter reloads.
REQ-022 Back-to-back RxValid in consecutive cycles SHALL be accepted without loss.
REQ-023 The counter SHALL saturate and never wrap while ACTIVE.

Reset
REQ-024 Reset=1 at a rising edge: state IDLE, index 0, counter 0, shift register 0, WriteData 32'h0, WriteStrobe 0, ComActive 0, WordDropped 0, Checksum 8'h00.
REQ-025 Reset mid-word or mid-session: partial data discarded silently; WordDropped stays 0; Reset overrides simultaneous RxValid.

Configuration
REQ-026 Macro CONFIG_PACKER_CHECKSUM_EN defined: Checksum = modulo-256 sum of all bytes accepted since ComActive rose; the accepted byte is added one cycle after its RxValid; Checksum clears to 0 when IDLE -> ACTIVE, with the first byte added to 0.
REQ-027 Macro undefined: Checksum port is still present, tied to 8'h00, and no adder is instantiated.

Structure
REQ-028 Shared package config_pkg: CONFIG_WORD_WIDTH=32, CONFIG_BYTE_WIDTH=8, CONFIG_SYNC_WORD=32'hFAB0_FAB1, and the packer state enum (IDLE, ACTIVE).
REQ-029 One sub-module, config_activity_timer: counter with reload, saturate and expire outputs, parameterised by TimeoutCycles/TimeoutWidth.

Verification
REQ-030 IDLE, bytes FA,B0,FA,B1 on consecutive cycles -> ComActive high from cycle after byte 1; WriteStrobe one cycle after byte 4 with WriteData=32'hFAB0FAB1.
REQ-031 Bytes 01,02,03,04,05,06,07,08 spaced 3 cycles apart -> two strobes, WriteData 32'h01020304 then 32'h05060708.
REQ-032 TimeoutCycles=8; 2 bytes then silence -> ComActive falls and WordDropped pulses together, 9 cycles after last byte; no strobe; next byte restarts the session at index 0.
REQ-033 TimeoutCycles=8; RxValid exactly on the expiry cycle -> ComActive stays high; counter restarts.
REQ-034 Reset asserted after 3 bytes, then bytes AA,BB,CC,DD -> single strobe with 32'hAABBCCDD; WordDropped never high.
REQ-035 With CONFIG_PACKER_CHECKSUM_EN, bytes FF,02,10,01 -> Checksum=8'h12 one cycle after last byte; after timeout and new byte 05 -> Checksum=8'h05; without the macro -> Checksum constant 8'h00.
